// File: rtl/neuron_mac.sv
// Sequential multiply-accumulate neuron: bias + dot product over LANES products per
// beat, then floor rescale, saturation and a selectable activation, with valid/ready on both sides.
module neuron_mac #(
    parameter int DATA_W     = 16,
    parameter int WEIGHT_W   = 16,
    parameter int BIAS_W     = 32,
    parameter int N_INPUTS   = 8,
    parameter int LANES      = 2,
    parameter int OUT_W      = 24,
    parameter int FRAC_SHIFT = 8,
    localparam int ACC_W     = DATA_W + WEIGHT_W + $clog2(N_INPUTS) + 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [N_INPUTS*DATA_W-1:0]      data_in,
    input  logic [N_INPUTS*WEIGHT_W-1:0]    weights,
    input  logic signed [BIAS_W-1:0]        bias,
    input  logic [1:0]                      act_mode,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic signed [OUT_W-1:0]         neuron_out,
    output logic                            sat_flag
);
    localparam int BEATS  = N_INPUTS / LANES;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, ACT, HOLD} state_t;

    state_t                         state_q;
    logic [N_INPUTS*DATA_W-1:0]     data_q;
    logic [N_INPUTS*WEIGHT_W-1:0]   weights_q;
    logic [1:0]                     mode_q;
    logic signed [ACC_W-1:0]        acc_q;
    logic [CNT_W-1:0]               cnt_q;
    logic signed [OUT_W-1:0]        neuron_out_q;
    logic                           sat_q;
    logic                           out_valid_q;

    logic signed [PROD_W-1:0]       prod [LANES];
    logic signed [ACC_W-1:0]        beat_sum_d;
    logic signed [ACC_W-1:0]        shifted;
    logic signed [OUT_W-1:0]        sat_val;
    logic signed [OUT_W-1:0]        out_d;
    logic                           sat_d;

    // Operand registers shift down one group per beat, so the lanes always read the low elements.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign prod[gi] = $signed(data_q[gi*DATA_W +: DATA_W])
                            * $signed(weights_q[gi*WEIGHT_W +: WEIGHT_W]);
        end
    endgenerate

    always_comb begin
        beat_sum_d = '0;
        for (int i = 0; i < LANES; i++) begin
            beat_sum_d = beat_sum_d + ACC_W'(prod[i]);
        end
    end

    assign shifted = acc_q >>> FRAC_SHIFT;

    always_comb begin
        sat_d   = 1'b0;
        sat_val = shifted[OUT_W-1:0];
        if (shifted > SAT_MAX) begin
            sat_val = SAT_MAX[OUT_W-1:0];
            sat_d   = 1'b1;
        end else if (shifted < SAT_MIN) begin
            sat_val = SAT_MIN[OUT_W-1:0];
            sat_d   = 1'b1;
        end
        out_d = sat_val;
        case (mode_q)
            2'b01:   if (sat_val[OUT_W-1]) out_d = '0;
            2'b10:   if (sat_val[OUT_W-1]) out_d = sat_val >>> 3;
            default: out_d = sat_val;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            data_q       <= '0;
            weights_q    <= '0;
            mode_q       <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            neuron_out_q <= '0;
            sat_q        <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    data_q    <= data_in;
                    weights_q <= weights;
                    mode_q    <= act_mode;
                    acc_q     <= ACC_W'(bias);
                    cnt_q     <= '0;
                    state_q   <= MAC;
                end
                MAC: begin
                    acc_q     <= acc_q + beat_sum_d;
                    data_q    <= data_q >> (LANES*DATA_W);
                    weights_q <= weights_q >> (LANES*WEIGHT_W);
                    cnt_q     <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(BEATS-1)) state_q <= ACT;
                end
                ACT: begin
                    neuron_out_q <= out_d;
                    sat_q        <= sat_d;
                    out_valid_q  <= 1'b1;
                    state_q      <= HOLD;
                end
                HOLD: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gated by rst so the block never advertises readiness while held in reset.
    assign in_ready   = (state_q == IDLE) && !rst;
    assign out_valid  = out_valid_q;
    assign neuron_out = neuron_out_q;
    assign sat_flag   = sat_q;
endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac: hand-computed vector table, random vectors against
// an arithmetic reference model, plus backpressure and mid-operation reset sequences.
module tb_neuron_mac;
    localparam int DW = 8, WW = 8, BW = 16, N = 4, L = 2, OW = 12, FS = 2;
    localparam int EXP_LAT = N / L + 1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [N*DW-1:0]        data_in = '0;
    logic [N*WW-1:0]        weights = '0;
    logic signed [BW-1:0]   bias = '0;
    logic [1:0]             act_mode = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic signed [OW-1:0]   neuron_out;
    logic                   sat_flag;

    int n_vec = 0;
    int n_bad = 0;

    neuron_mac #(
        .DATA_W(DW), .WEIGHT_W(WW), .BIAS_W(BW), .N_INPUTS(N),
        .LANES(L), .OUT_W(OW), .FRAC_SHIFT(FS)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .weights(weights), .bias(bias), .act_mode(act_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .neuron_out(neuron_out), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]        d;
        logic [31:0]        w;
        logic signed [15:0] b;
        logic [1:0]         m;
        logic signed [11:0] eo;
        logic               es;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        logic [31:0] r;
        r = {d[7:0], c[7:0], b[7:0], a[7:0]};
        return r;
    endfunction

    function automatic vec_t mk(input int x0, input int x1, input int x2, input int x3,
                                input int w0, input int w1, input int w2, input int w3,
                                input int b, input int m, input int eo, input int es);
        vec_t v;
        v.d  = pack4(x0, x1, x2, x3);
        v.w  = pack4(w0, w1, w2, w3);
        v.b  = 16'(b);
        v.m  = 2'(m);
        v.eo = 12'(eo);
        v.es = es[0];
        return v;
    endfunction

    // Reference: exact integer dot product, floor division by 2^FS, clamp, activation.
    function automatic void model(input logic [31:0] d, input logic [31:0] w, input int b,
                                  input int m, output int o, output int s);
        int sum, q;
        sum = b;
        for (int i = 0; i < N; i++) begin
            sum += int'($signed(d[i*8 +: 8])) * int'($signed(w[i*8 +: 8]));
        end
        if (sum >= 0) q = sum / 4;
        else          q = -((-sum + 3) / 4);
        s = 0;
        if (q > 2047) begin q = 2047; s = 1; end
        else if (q < -2048) begin q = -2048; s = 1; end
        if (m == 1 && q < 0) q = 0;
        if (m == 2 && q < 0) q = -((-q + 7) / 8);
        o = q;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [31:0] w, input int b, input int m);
        int k;
        @(negedge clk);
        data_in  = d;
        weights  = w;
        bias     = 16'(b);
        act_mode = 2'(m);
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("in_ready_before_accept", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_in  = $urandom;
        weights  = $urandom;
        bias     = 16'($urandom);
        act_mode = 2'($urandom);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_after_transfer", int'(out_valid), 0);
        check("in_ready_after_transfer", int'(in_ready), 1);
    endtask

    task automatic run_txn(input string name, input logic [31:0] d, input logic [31:0] w,
                           input int b, input int m, input int eo, input int es);
        int lat;
        send(d, w, b, m);
        wait_out(lat);
        check({name, "_latency"}, lat, EXP_LAT);
        check({name, "_out"}, int'(neuron_out), eo);
        check({name, "_sat"}, int'(sat_flag), es);
        $display("txn %s: x=%h w=%h b=%0d m=%0d -> out=%0d sat=%0d lat=%0d",
                 name, d, w, b, m, neuron_out, sat_flag, lat);
        release_out();
    endtask

    initial begin
        int eo, es, b, m, hold_out, hold_sat, ever_valid;
        logic [31:0] d, w;

        tbl[0]  = mk(  1,   2,   3,   4,   1,   1,   1,   1,     0, 0,     2, 0);
        tbl[1]  = mk(-10,   0,   0,   0,   4,   0,   0,   0,     0, 0,   -10, 0);
        tbl[2]  = mk(-10,   0,   0,   0,   4,   0,   0,   0,     0, 1,     0, 0);
        tbl[3]  = mk(-10,   0,   0,   0,   4,   0,   0,   0,     0, 2,    -2, 0);
        tbl[4]  = mk(-10,   0,   0,   0,   4,   0,   0,   0,     0, 3,   -10, 0);
        tbl[5]  = mk(127, 127, 127, 127, 127, 127, 127, 127,     0, 0,  2047, 1);
        tbl[6]  = mk(-128,-128,-128,-128,127, 127, 127, 127,     0, 0, -2048, 1);
        tbl[7]  = mk(-128,-128,-128,-128,127, 127, 127, 127,     0, 1,     0, 1);
        tbl[8]  = mk(-128,-128,-128,-128,127, 127, 127, 127,     0, 2,  -256, 1);
        tbl[9]  = mk(  0,   0,   0,   0,   0,   0,   0,   0,    -8, 0,    -2, 0);
        tbl[10] = mk(  0,   0,   0,   0,   0,   0,   0,   0,  8188, 0,  2047, 0);
        tbl[11] = mk(  0,   0,   0,   0,   0,   0,   0,   0,  8192, 0,  2047, 1);
        tbl[12] = mk(  0,   0,   0,   0,   0,   0,   0,   0, -8192, 0, -2048, 0);
        tbl[13] = mk(  0,   0,   0,   0,   0,   0,   0,   0, -8196, 0, -2048, 1);
        tbl[14] = mk(  0,   0,   0,   0,   0,   0,   0,   0,     7, 2,     1, 0);
        tbl[15] = mk(  0,   0,   0,   0,   0,   0,   0,   0,    -9, 2,    -1, 0);

        // Reset state while rst is held
        @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_neuron_out", int'(neuron_out), 0);
        check("rst_sat_flag", int'(sat_flag), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", int'(in_ready), 1);

        for (int i = 0; i < 16; i++) begin
            run_txn($sformatf("tbl%0d", i), tbl[i].d, tbl[i].w, int'(tbl[i].b),
                    int'(tbl[i].m), int'(tbl[i].eo), int'(tbl[i].es));
        end

        for (int i = 0; i < 40; i++) begin
            d = $urandom;
            w = $urandom;
            b = (i % 4 == 0) ? int'($urandom_range(0, 65535)) - 32768
                             : int'($urandom_range(0, 4095)) - 2048;
            m = int'($urandom_range(0, 3));
            model(d, w, b, m, eo, es);
            run_txn($sformatf("rnd%0d", i), d, w, b, m, eo, es);
        end

        // Backpressure: result held, new operands refused while waiting
        send(tbl[5].d, tbl[5].w, 0, 0);
        wait_out(hold_out);
        check("bp_latency", hold_out, EXP_LAT);
        hold_out = int'(neuron_out);
        hold_sat = int'(sat_flag);
        check("bp_out", hold_out, 2047);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            data_in  = tbl[0].d;
            weights  = tbl[0].w;
            bias     = '0;
            act_mode = 2'b00;
            @(posedge clk);
            #1;
            check("bp_out_valid_held", int'(out_valid), 1);
            check("bp_out_held", int'(neuron_out), hold_out);
            check("bp_sat_held", int'(sat_flag), hold_sat);
            check("bp_in_ready_low", int'(in_ready), 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_transfer_out_valid", int'(out_valid), 0);
        check("bp_transfer_in_ready", int'(in_ready), 1);
        ever_valid = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid || !in_ready) ever_valid = 1;
        end
        check("bp_no_stray_accept", ever_valid, 0);

        // Reset one cycle after acceptance: outputs clear at once, result never appears
        send(tbl[0].d, tbl[0].w, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_neuron_out", int'(neuron_out), 0);
        check("midrst_sat_flag", int'(sat_flag), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        ever_valid = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) ever_valid = 1;
        end
        check("midrst_never_valid", ever_valid, 0);
        check("midrst_idle_ready", int'(in_ready), 1);
        run_txn("after_rst", tbl[0].d, tbl[0].w, 0, 0, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
